adc_block_sequencer: RTL



---
 rtl/adc_seq_pkg.sv | 20 ++
 rtl/adc_block_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/adc_seq_pkg.sv
// State encodings shared by the block sequencer and anything decoding its state output.
// Purely declarative; no logic, no latency, no flow control.
// The encodings are visible to software through the register bank, so keep them stable.
package adc_seq_pkg;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_ARM_ENC  = 3'd1;
    localparam logic [2:0] ST_RUN_ENC  = 3'd2;
    localparam logic [2:0] ST_LAST_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ARM  = ST_ARM_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_LAST = ST_LAST_ENC,
        ST_DONE = ST_DONE_ENC
    } adc_seq_state_t;

endpackage

// File: rtl/adc_block_sequencer.sv
// Sequences block acquisitions: gates ADC ready, marks block ends, reports progress/overrun/done.
// Latency: start -> ARM next cycle, RUN one cycle after dma_ready; every output is registered.
// Backpressure: dma_ready low holds ARM; a trigger during RUN with dma_ready low sets sticky overrun.
module adc_block_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [CNT_WIDTH-1:0] block_len,
    input  logic [CNT_WIDTH-1:0] num_blocks,
    input  logic                 dma_ready,
    input  logic                 trigger,
    output logic                 adc_ready,
    output logic                 adc_last,
    output logic                 restart,
    output logic [CNT_WIDTH-1:0] sample_idx,
    output logic [CNT_WIDTH-1:0] block_idx,
    output adc_seq_state_t       state,
    output logic                 block_done,
    output logic                 run_done,
    output logic                 overrun,
    output logic                 aborted
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] len_eff;
    logic [CNT_WIDTH-1:0] nblk_eff;
    logic                 cont_lat;
    logic [CNT_WIDTH-1:0] sample_nxt;
    logic [CNT_WIDTH-1:0] block_nxt;

    assign sample_nxt = sample_idx + ONE;
    assign block_nxt  = block_idx + ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            adc_ready  <= 1'b0;
            adc_last   <= 1'b0;
            restart    <= 1'b0;
            sample_idx <= '0;
            block_idx  <= '0;
            block_done <= 1'b0;
            run_done   <= 1'b0;
            overrun    <= 1'b0;
            aborted    <= 1'b0;
            len_eff    <= ONE;
            nblk_eff   <= ONE;
            cont_lat   <= 1'b0;
        end else begin
            adc_last   <= 1'b0;
            restart    <= 1'b0;
            block_done <= 1'b0;
            run_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        // Zero lengths are normalised once here so the compare in RUN stays simple.
                        len_eff    <= (block_len == '0) ? ONE : block_len;
                        nblk_eff   <= (num_blocks == '0) ? ONE : num_blocks;
                        cont_lat   <= continuous;
                        sample_idx <= '0;
                        block_idx  <= '0;
                        overrun    <= 1'b0;
                        aborted    <= 1'b0;
                        state      <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (stop) begin
                        aborted  <= 1'b1;
                        run_done <= 1'b1;
                        state    <= ST_DONE;
                    end else if (dma_ready) begin
                        adc_ready <= 1'b1;
                        restart   <= (block_idx != '0);
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // stop outranks a simultaneous final trigger: the partial block is discarded.
                    if (stop) begin
                        adc_ready <= 1'b0;
                        adc_last  <= 1'b1;
                        aborted   <= 1'b1;
                        run_done  <= 1'b1;
                        state     <= ST_DONE;
                    end else if (trigger) begin
                        sample_idx <= sample_nxt;
                        if (!dma_ready) begin
                            overrun <= 1'b1;
                        end
                        if (sample_nxt == len_eff) begin
                            adc_ready  <= 1'b0;
                            adc_last   <= 1'b1;
                            block_done <= 1'b1;
                            block_idx  <= block_nxt;
                            state      <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    // block_idx already counts the block that just finished.
                    if (stop) begin
                        aborted  <= 1'b1;
                        run_done <= 1'b1;
                        state    <= ST_DONE;
                    end else if (cont_lat || (block_idx < nblk_eff)) begin
                        sample_idx <= '0;
                        state      <= ST_ARM;
                    end else begin
                        run_done <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    adc_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
